// File: rtl/mem_read_a_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mm_pkg : shared types and default sizes for the A-matrix read path
// Revision : 1.0
// ---------------------------------------------------------------------------
package mm_pkg;

   localparam int N1_DEFAULT           = 4;
   localparam int ADDR_W_DEFAULT       = 12;
   localparam int MATRIXSIZE_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_read_a_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_read_a_if : control, dimension and bank-read bundle of mem_read_a
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mem_read_a_if
   import mm_pkg::*;
#(
   parameter int N1           = N1_DEFAULT,
   parameter int ADDR_W       = ADDR_W_DEFAULT,
   parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEFAULT
) ();

   logic                    start;
   logic [MATRIXSIZE_W-1:0] M2;
   logic [MATRIXSIZE_W-1:0] M1dN1;
   logic [MATRIXSIZE_W-1:0] M3dN2;
   logic                    ready;
   logic [N1*ADDR_W-1:0]    rd_addr_A;
   logic [N1-1:0]           rd_en_A;
   logic                    busy;
   logic                    done;

   modport master (
      output start, M2, M1dN1, M3dN2, ready,
      input  rd_addr_A, rd_en_A, busy, done
   );

   modport slave (
      input  start, M2, M1dN1, M3dN2, ready,
      output rd_addr_A, rd_en_A, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/mem_read_a_addr_skew_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// addr_skew_line : ready-gated {en,addr} delay line, tap i lags tap 0 by i
// Revision : 1.0   (requires N1 >= 2)
// ---------------------------------------------------------------------------
module addr_skew_line
   import mm_pkg::*;
#(
   parameter int N1     = N1_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ready,
   input  logic [ADDR_W:0]          din,
   output logic [N1-1:0][ADDR_W:0]  taps
);

   logic [N1-1:1][ADDR_W:0] line_q, line_d;

   always_comb begin
      line_d = line_q;
      if (ready) begin
         line_d[1] = din;
         for (int i = 2; i < N1; i++) begin
            line_d[i] = line_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   always_comb begin
      taps[0] = din;
      for (int i = 1; i < N1; i++) begin
         taps[i] = line_q[i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_read_a.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_read_a : streams A row-blocks from N1 banks, one column per ready cycle
// Revision : 1.0   Option: MEM_READ_A_SKEW_EN (systolic per-bank input skew)
// ---------------------------------------------------------------------------
module mem_read_a
   import mm_pkg::*;
#(
   parameter int N1           = N1_DEFAULT,
   parameter int ADDR_W       = ADDR_W_DEFAULT,
   parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   mem_read_a_if.slave  bus
);

   rd_state_e               state_q, state_d;
   logic [MATRIXSIZE_W-1:0] m2_q, m2_d, m1_q, m1_d, m3_q, m3_d;
   logic [MATRIXSIZE_W-1:0] col_q, col_d, rep_q, rep_d, blk_q, blk_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic [ADDR_W:0]         stage_q, stage_d;

   logic                    idle;
   logic [MATRIXSIZE_W-1:0] cur_m2, cur_m1, cur_m3, cur_col, cur_rep, cur_blk;
   logic [ADDR_W-1:0]       cur_base, issue_addr;
   logic                    want_issue, issue, dims_zero;
   logic                    last_col, last_rep, last_blk;

`ifdef MEM_READ_A_SKEW_EN
   localparam int DRAIN_W = (N1 > 2) ? $clog2(N1 - 1) : 1;
   logic [DRAIN_W-1:0] drain_q, drain_d;
`endif

   // The start-acceptance cycle already issues column 0, so IDLE sees the
   // live dimension inputs and zeroed loop counters.
   always_comb begin
      idle       = (state_q == IDLE);
      cur_m2     = idle ? bus.M2    : m2_q;
      cur_m1     = idle ? bus.M1dN1 : m1_q;
      cur_m3     = idle ? bus.M3dN2 : m3_q;
      cur_col    = idle ? '0 : col_q;
      cur_rep    = idle ? '0 : rep_q;
      cur_blk    = idle ? '0 : blk_q;
      cur_base   = idle ? '0 : base_q;
      dims_zero  = (bus.M2 == '0) || (bus.M1dN1 == '0) || (bus.M3dN2 == '0);
      last_col   = (cur_col == cur_m2 - MATRIXSIZE_W'(1));
      last_rep   = (cur_rep == cur_m3 - MATRIXSIZE_W'(1));
      last_blk   = (cur_blk == cur_m1 - MATRIXSIZE_W'(1));
      issue_addr = cur_base + cur_col[ADDR_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      m2_d       = m2_q;
      m1_d       = m1_q;
      m3_d       = m3_q;
      col_d      = col_q;
      rep_d      = rep_q;
      blk_d      = blk_q;
      base_d     = base_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      want_issue = 1'b0;
`ifdef MEM_READ_A_SKEW_EN
      drain_d    = drain_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               m2_d   = bus.M2;
               m1_d   = bus.M1dN1;
               m3_d   = bus.M3dN2;
               busy_d = 1'b1;
               col_d  = '0;
               rep_d  = '0;
               blk_d  = '0;
               base_d = '0;
               if (dims_zero) begin
                  state_d = DONE;
               end else begin
                  state_d    = RUN;
                  want_issue = 1'b1;
               end
            end
         end
         RUN: want_issue = 1'b1;
         DRAIN: begin
`ifdef MEM_READ_A_SKEW_EN
            if (bus.ready) begin
               if (drain_q == DRAIN_W'(N1 - 2)) begin
                  state_d = DONE;
               end else begin
                  drain_d = drain_q + DRAIN_W'(1);
               end
            end
`else
            state_d = DONE;
`endif
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      issue = want_issue & bus.ready;
      if (issue) begin
         // Replay rewinds the column only; a block step moves the base by M2.
         if (last_col) begin
            col_d = '0;
            if (last_rep) begin
               rep_d  = '0;
               blk_d  = cur_blk + MATRIXSIZE_W'(1);
               base_d = cur_base + cur_m2[ADDR_W-1:0];
            end else begin
               rep_d = cur_rep + MATRIXSIZE_W'(1);
            end
         end else begin
            col_d = cur_col + MATRIXSIZE_W'(1);
         end
         if (last_col && last_rep && last_blk) begin
`ifdef MEM_READ_A_SKEW_EN
            state_d = DRAIN;
            drain_d = '0;
`else
            state_d = DONE;
`endif
         end
      end

      stage_d = bus.ready ? {issue, (issue ? issue_addr : {ADDR_W{1'b0}})} : stage_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         m2_q    <= '0;
         m1_q    <= '0;
         m3_q    <= '0;
         col_q   <= '0;
         rep_q   <= '0;
         blk_q   <= '0;
         base_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         stage_q <= '0;
`ifdef MEM_READ_A_SKEW_EN
         drain_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         m2_q    <= m2_d;
         m1_q    <= m1_d;
         m3_q    <= m3_d;
         col_q   <= col_d;
         rep_q   <= rep_d;
         blk_q   <= blk_d;
         base_q  <= base_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         stage_q <= stage_d;
`ifdef MEM_READ_A_SKEW_EN
         drain_q <= drain_d;
`endif
      end
   end

   logic [N1-1:0][ADDR_W:0] taps;

`ifdef MEM_READ_A_SKEW_EN
   addr_skew_line #(
      .N1     (N1),
      .ADDR_W (ADDR_W)
   ) u_skew (
      .clk   (clk),
      .rst   (rst),
      .ready (bus.ready),
      .din   (stage_q),
      .taps  (taps)
   );
`else
   always_comb taps = {N1{stage_q}};
`endif

   logic [N1*ADDR_W-1:0] rd_addr;
   logic [N1-1:0]        rd_en;

   always_comb begin
      rd_addr = '0;
      rd_en   = '0;
      for (int i = 0; i < N1; i++) begin
         rd_en[i]                      = taps[i][ADDR_W];
         rd_addr[i*ADDR_W +: ADDR_W]   = taps[i][ADDR_W-1:0];
      end
   end

   assign bus.rd_addr_A = rd_addr;
   assign bus.rd_en_A   = rd_en;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
`default_nettype wire
